time_set_controller: RTL and testbench

- User-facing time-set front end for the HH:MM:SS up/down clock. It writes time into the second, minute and hour counter chain, which normally only produces time.
- Key presses step through hour, minute and second fields. Each field is edited in a shadow register while the counters are frozen.
- On exit, a one-cycle load strobe with the new values is issued. The selected field blinks on the HEX display through a blank mask.

---
 rtl/time_set_controller_pkg.sv | 22 ++
 rtl/time_set_controller_if.sv | 23 ++
 rtl/time_set_controller_field_wrap_counter.sv | 31 +++
 rtl/time_set_controller.sv | 174 +++++++++++++++++
 tb/tb_time_set_controller.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/time_set_controller_pkg.sv
// Shared types and constants for the time-set front end of the HH:MM:SS clock.
package time_set_controller_pkg;

  typedef enum logic [2:0] {
    RUN       = 3'd0,
    EDIT_HOUR = 3'd1,
    EDIT_MIN  = 3'd2,
    EDIT_SEC  = 3'd3,
    COMMIT    = 3'd4
  } state_t;

  localparam int HOUR_MAX = 23;
  localparam int MS_MAX   = 59;
  localparam int SEC_W    = 6;
  localparam int MIN_W    = 6;
  localparam int HOUR_W   = 5;

  function automatic logic is_edit(input state_t s);
    return (s == EDIT_HOUR) || (s == EDIT_MIN) || (s == EDIT_SEC);
  endfunction

endpackage

// File: rtl/time_set_controller_if.sv
// Bus between the time-set controller (master) and the sec/min/hour counter chain (slave).
interface time_set_controller_if;
  import time_set_controller_pkg::*;

  logic [SEC_W-1:0]  cur_sec;
  logic [MIN_W-1:0]  cur_min;
  logic [HOUR_W-1:0] cur_hour;
  logic              run_en;
  logic              load_en;
  logic [SEC_W-1:0]  load_sec;
  logic [MIN_W-1:0]  load_min;
  logic [HOUR_W-1:0] load_hour;

  modport master (
    input  cur_sec, cur_min, cur_hour,
    output run_en, load_en, load_sec, load_min, load_hour
  );

  modport slave (
    output cur_sec, cur_min, cur_hour,
    input  run_en, load_en, load_sec, load_min, load_hour
  );
endinterface

// File: rtl/time_set_controller_field_wrap_counter.sv
// Shadow register for one time field: parallel load, or +1/-1 wrapping between 0 and MAX.
module field_wrap_counter #(
  parameter int W   = 6,
  parameter int MAX = 59
) (
  input  logic         CLOCK_50_div,
  input  logic         debouncer_rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] value
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge CLOCK_50_div or posedge debouncer_rst) begin
    if (debouncer_rst) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else if (en && inc && !dec) begin
      value <= (value == MAX_V) ? '0 : value + W'(1);
    end else if (en && dec && !inc) begin
      value <= (value == '0) ? MAX_V : value - W'(1);
    end
  end

endmodule

// File: rtl/time_set_controller.sv
// Time-set front end: freezes the counters, edits hour/min/sec shadows with blink and
// idle timeout, then issues a one-cycle load strobe with the edited time.
module time_set_controller
  import time_set_controller_pkg::*;
#(
  parameter int BLINK_HALF = 25,
  parameter int TIMEOUT    = 500
) (
  input  logic                         CLOCK_50_div,
  input  logic                         debouncer_rst,
  input  logic                         key_mode,
  input  logic                         key_inc,
  input  logic                         key_dec,
  time_set_controller_if.master        cnt_bus,
  output logic [2:0]                   blank_mask,
  output logic                         editing
);

  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam int IW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);
  localparam logic [IW-1:0] IDLE_LAST  = IW'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic              prev_mode, prev_inc, prev_dec;
  logic              press_mode, press_inc, press_dec, any_press;
  logic [BW-1:0]     blink_q, blink_d;
  logic              phase_q, phase_d;
  logic [IW-1:0]     idle_q, idle_d;
  logic [2:0]        blank_d;
  logic              capture;
  logic [HOUR_W-1:0] sh_hour;
  logic [MIN_W-1:0]  sh_min;
  logic [SEC_W-1:0]  sh_sec;

  // Previous levels reset to 1 so a key held through reset release is not a press.
  always_ff @(posedge CLOCK_50_div or posedge debouncer_rst) begin
    if (debouncer_rst) begin
      prev_mode <= 1'b1;
      prev_inc  <= 1'b1;
      prev_dec  <= 1'b1;
    end else begin
      prev_mode <= key_mode;
      prev_inc  <= key_inc;
      prev_dec  <= key_dec;
    end
  end

  assign press_mode = key_mode & ~prev_mode;
  assign press_inc  = key_inc & ~prev_inc;
  assign press_dec  = key_dec & ~prev_dec;
  assign any_press  = press_mode | press_inc | press_dec;
  assign capture    = (state_q == RUN) && press_mode;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:       if (press_mode) state_d = EDIT_HOUR;
      EDIT_HOUR: if (press_mode) state_d = EDIT_MIN;
                 else if (!any_press && idle_q == IDLE_LAST) state_d = RUN;
      EDIT_MIN:  if (press_mode) state_d = EDIT_SEC;
                 else if (!any_press && idle_q == IDLE_LAST) state_d = RUN;
      EDIT_SEC:  if (press_mode) state_d = COMMIT;
                 else if (!any_press && idle_q == IDLE_LAST) state_d = RUN;
      COMMIT:    state_d = RUN;
      default:   state_d = RUN;
    endcase
  end

  // Blink phase and idle count restart on every field entry; inc/dec re-show the field.
  always_comb begin
    blink_d = blink_q;
    phase_d = phase_q;
    idle_d  = idle_q;
    if (!is_edit(state_d) || state_d != state_q) begin
      blink_d = '0;
      phase_d = 1'b0;
      idle_d  = '0;
    end else begin
      idle_d = any_press ? '0 : idle_q + IW'(1);
      if (press_inc || press_dec) begin
        blink_d = '0;
        phase_d = 1'b0;
      end else if (blink_q == BLINK_LAST) begin
        blink_d = '0;
        phase_d = ~phase_q;
      end else begin
        blink_d = blink_q + BW'(1);
      end
    end
  end

  always_comb begin
    blank_d = 3'b000;
    case (state_d)
      EDIT_HOUR: blank_d[2] = phase_d;
      EDIT_MIN:  blank_d[1] = phase_d;
      EDIT_SEC:  blank_d[0] = phase_d;
      default:   blank_d = 3'b000;
    endcase
  end

  always_ff @(posedge CLOCK_50_div or posedge debouncer_rst) begin
    if (debouncer_rst) begin
      state_q <= RUN;
      blink_q <= '0;
      phase_q <= 1'b0;
      idle_q  <= '0;
    end else begin
      state_q <= state_d;
      blink_q <= blink_d;
      phase_q <= phase_d;
      idle_q  <= idle_d;
    end
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge CLOCK_50_div or posedge debouncer_rst) begin
    if (debouncer_rst) begin
      cnt_bus.run_en    <= 1'b1;
      cnt_bus.load_en   <= 1'b0;
      cnt_bus.load_sec  <= '0;
      cnt_bus.load_min  <= '0;
      cnt_bus.load_hour <= '0;
      blank_mask        <= 3'b000;
      editing           <= 1'b0;
    end else begin
      cnt_bus.run_en  <= (state_d == RUN);
      cnt_bus.load_en <= (state_d == COMMIT);
      blank_mask      <= blank_d;
      editing         <= is_edit(state_d);
      if (state_d == COMMIT) begin
        cnt_bus.load_sec  <= sh_sec;
        cnt_bus.load_min  <= sh_min;
        cnt_bus.load_hour <= sh_hour;
      end
    end
  end

  field_wrap_counter #(.W(HOUR_W), .MAX(HOUR_MAX)) u_hour (
    .CLOCK_50_div  (CLOCK_50_div),
    .debouncer_rst (debouncer_rst),
    .load          (capture),
    .load_val      (cnt_bus.cur_hour),
    .en            ((state_q == EDIT_HOUR) && !press_mode),
    .inc           (press_inc),
    .dec           (press_dec),
    .value         (sh_hour)
  );

  field_wrap_counter #(.W(MIN_W), .MAX(MS_MAX)) u_min (
    .CLOCK_50_div  (CLOCK_50_div),
    .debouncer_rst (debouncer_rst),
    .load          (capture),
    .load_val      (cnt_bus.cur_min),
    .en            ((state_q == EDIT_MIN) && !press_mode),
    .inc           (press_inc),
    .dec           (press_dec),
    .value         (sh_min)
  );

  field_wrap_counter #(.W(SEC_W), .MAX(MS_MAX)) u_sec (
    .CLOCK_50_div  (CLOCK_50_div),
    .debouncer_rst (debouncer_rst),
    .load          (capture),
    .load_val      (cnt_bus.cur_sec),
    .en            ((state_q == EDIT_SEC) && !press_mode),
    .inc           (press_inc),
    .dec           (press_dec),
    .value         (sh_sec)
  );

endmodule

// File: tb/tb_time_set_controller.sv
// Directed self-checking bench for time_set_controller (BLINK_HALF = 25, TIMEOUT = 500).
module tb_time_set_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_mode = 1'b0;
  logic       key_inc  = 1'b0;
  logic       key_dec  = 1'b0;
  logic [2:0] blank_mask;
  logic       editing;
  int         errors = 0;
  int         checks = 0;
  int         load_cnt = 0;

  time_set_controller_if bus ();

  time_set_controller #(.BLINK_HALF(25), .TIMEOUT(500)) dut (
    .CLOCK_50_div  (clk),
    .debouncer_rst (rst),
    .key_mode      (key_mode),
    .key_inc       (key_inc),
    .key_dec       (key_dec),
    .cnt_bus       (bus),
    .blank_mask    (blank_mask),
    .editing       (editing)
  );

  always #10 clk = ~clk;

  always @(negedge clk) if (bus.load_en === 1'b1) load_cnt++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input logic m, input logic i, input logic d);
    key_mode = m; key_inc = i; key_dec = d;
    tick();
    key_mode = 1'b0; key_inc = 1'b0; key_dec = 1'b0;
    tick();
  endtask

  task automatic set_cur(input int h, input int m, input int s);
    bus.cur_hour = 5'(h);
    bus.cur_min  = 6'(m);
    bus.cur_sec  = 6'(s);
  endtask

  initial begin
    // Reset with mode held: no edit entry after release.
    set_cur(12, 34, 56);
    key_mode = 1'b1;
    #25;
    check("rst_run_en",    bus.run_en,    1);
    check("rst_load_en",   bus.load_en,   0);
    check("rst_load_hour", bus.load_hour, 0);
    check("rst_blank",     blank_mask,    0);
    check("rst_editing",   editing,       0);
    @(posedge clk); #1;
    rst = 1'b0;
    tick(3);
    check("held_mode_editing", editing,    0);
    check("held_mode_run_en",  bus.run_en, 1);
    key_mode = 1'b0;
    tick();

    // 12:34:56, hour +2, commit 14:34:56.
    key_mode = 1'b1;
    tick();
    check("enter_editing", editing,    1);
    check("enter_run_en",  bus.run_en, 0);
    check("enter_blank",   blank_mask, 0);
    key_mode = 1'b0;
    tick();
    press(0, 1, 0);
    press(0, 1, 0);
    press(1, 0, 0);
    press(1, 0, 0);
    key_mode = 1'b1;
    tick();
    check("commit_load_en",   bus.load_en,   1);
    check("commit_run_en",    bus.run_en,    0);
    check("commit_load_hour", bus.load_hour, 14);
    check("commit_load_min",  bus.load_min,  34);
    check("commit_load_sec",  bus.load_sec,  56);
    key_mode = 1'b0;
    tick();
    check("post_load_en",   bus.load_en,   0);
    check("post_run_en",    bus.run_en,    1);
    check("post_hold_hour", bus.load_hour, 14);
    check("load_pulses_1",  load_cnt,      1);

    // Wrap boundaries and simultaneous inc/dec.
    set_cur(23, 0, 59);
    press(1, 0, 0);
    press(0, 1, 0);
    press(1, 0, 0);
    press(0, 0, 1);
    press(1, 0, 0);
    press(0, 1, 0);
    press(0, 1, 1);
    key_mode = 1'b1;
    tick();
    check("wrap_hour_23_inc", bus.load_hour, 0);
    check("wrap_min_0_dec",   bus.load_min,  59);
    check("wrap_sec_inc_pair", bus.load_sec, 0);
    key_mode = 1'b0;
    tick();
    check("load_pulses_2", load_cnt, 2);

    // Blink in EDIT_MIN, k = edges since entry.
    set_cur(1, 2, 3);
    press(1, 0, 0);
    key_mode = 1'b1;
    tick();
    key_mode = 1'b0;
    check("blink_k0", blank_mask, 3'b000);
    tick(24);
    check("blink_k24", blank_mask, 3'b000);
    tick(1);
    check("blink_k25", blank_mask, 3'b010);
    tick(24);
    check("blink_k49", blank_mask, 3'b010);
    tick(1);
    check("blink_k50", blank_mask, 3'b000);
    tick(30);
    check("blink_k80", blank_mask, 3'b010);
    key_inc = 1'b1;
    tick();
    check("blink_inc_clear", blank_mask, 3'b000);
    key_inc = 1'b0;
    tick();
    press(1, 1, 0);
    check("sec_editing", editing, 1);
    tick(24);
    check("sec_blink", blank_mask, 3'b001);
    key_mode = 1'b1;
    tick();
    check("prio_load_hour", bus.load_hour, 1);
    check("prio_load_min",  bus.load_min,  3);
    check("prio_load_sec",  bus.load_sec,  3);
    key_mode = 1'b0;
    tick();
    check("load_pulses_3", load_cnt, 3);

    // Idle timeout: abort without load.
    set_cur(5, 6, 7);
    key_mode = 1'b1;
    tick();
    key_mode = 1'b0;
    tick(499);
    check("timeout_k499_editing", editing,    1);
    check("timeout_k499_run_en",  bus.run_en, 0);
    tick(1);
    check("timeout_editing",   editing,       0);
    check("timeout_run_en",    bus.run_en,    1);
    check("timeout_load_en",   bus.load_en,   0);
    check("timeout_no_load",   load_cnt,      3);
    check("timeout_hold_hour", bus.load_hour, 1);

    // Reset during EDIT_SEC.
    set_cur(10, 20, 30);
    press(1, 0, 0);
    press(1, 0, 0);
    press(1, 0, 0);
    press(0, 1, 0);
    check("esec_editing", editing, 1);
    #3;
    rst = 1'b1;
    #1;
    check("midrst_run_en",    bus.run_en,    1);
    check("midrst_editing",   editing,       0);
    check("midrst_blank",     blank_mask,    0);
    check("midrst_load_en",   bus.load_en,   0);
    check("midrst_load_hour", bus.load_hour, 0);
    check("midrst_load_sec",  bus.load_sec,  0);
    tick(2);
    rst = 1'b0;
    tick(5);
    check("after_rst_run_en",  bus.run_en, 1);
    check("after_rst_editing", editing,    0);
    check("after_rst_no_load", load_cnt,   3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
